joy_db15_tx: RTL

- Device-side model of the DB15 splitter's serial joystick link: a 74HC165-style parallel-in/serial-out chain.
- Accepts two active-high 12-bit joystick vectors and drives the active-low serial data line.
- Responds to the host's load and clock strobes, which are asynchronous to clk.
- Used as the loopback/test responder for the splitter reader and in cores that emulate the splitter toward an external host.

---
 rtl/joy_db15_tx_if.sv | 15 +
 rtl/joy_db15_tx.sv | 108 ++++++++++
 2 files changed

// File: rtl/joy_db15_tx_if.sv
// rtl/joy_db15_tx_if.sv - DB15 splitter serial joystick link
// Purpose: bundles the three wires of the host <-> device serial link.
// Signals:
//   joy_clk  - host shift clock, data advances on its rising edge
//   joy_load - host parallel load, active-low
//   joy_data - serial data toward the host, active-low buttons
// Modports: master = host side, slave = device side (joy_db15_tx).
interface joy_db15_tx_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - device-side 74HC165-style joystick serialiser
// Purpose: presents two 12-bit active-high joystick vectors as a 24-bit
// active-low serial frame, clocked by an asynchronous host strobe pair.
// Ports:
//   i_clk        - system clock
//   i_reset      - synchronous active-high reset
//   i_joystick1  - player 1 buttons [11]Sel [10]Start [9]F [8]E [7]D [6]C
//                  [5]B [4]A [3]Up [2]Down [1]Left [0]Right
//   i_joystick2  - player 2 buttons, same layout
//   o_frame_done - one-clk pulse when the last frame bit is presented
//   link         - serial link (slave): joy_clk, joy_load in, joy_data out
module joy_db15_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PAD_BITS    = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [11:0]         i_joystick1,
  input  logic [11:0]         i_joystick2,
  output logic                o_frame_done,
  joy_db15_tx_if.slave        link
);

  localparam int W  = PAD_BITS + 24;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, LOADING, SHIFTING} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_clk_prev;
  logic [W-1:0]           r_shift;
  logic [CW-1:0]          r_cnt;
  logic                   r_joy_data;
  logic                   r_frame_done;

  logic                   w_sync_clk;
  logic                   w_sync_load;
  logic                   w_clk_rise;
  logic [23:0]            w_frame;
  logic [W-1:0]           w_load_val;

  assign w_sync_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_sync_load = r_load_sync[SYNC_STAGES-1];
  assign w_clk_rise  = w_sync_clk & ~r_clk_prev;

  // Frame bit 0 lands in bit 23 so it is the first bit to reach the MSB
  // once the pad bits have been shifted out.
  assign w_frame = ~{i_joystick1[7], i_joystick1[6], i_joystick1[5], i_joystick1[4],
                     i_joystick1[0], i_joystick1[1], i_joystick1[2], i_joystick1[3],
                     i_joystick2[0], i_joystick2[1], i_joystick2[2], i_joystick2[3],
                     i_joystick1[9], i_joystick1[8], i_joystick1[11], i_joystick1[10],
                     i_joystick2[9], i_joystick2[8], i_joystick2[11], i_joystick2[10],
                     i_joystick2[7], i_joystick2[6], i_joystick2[5], i_joystick2[4]};

  // Pad bits above the frame stay at 1.
  always_comb begin
    w_load_val        = '1;
    w_load_val[23:0]  = w_frame;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_clk_sync   <= '1;
      r_load_sync  <= '1;
      r_clk_prev   <= 1'b1;
      r_shift      <= '1;
      r_cnt        <= '0;
      r_joy_data   <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], link.joy_clk};
      r_load_sync  <= {r_load_sync[SYNC_STAGES-2:0], link.joy_load};
      r_clk_prev   <= w_sync_clk;
      r_frame_done <= 1'b0;

      if (!w_sync_load) begin
        // Transparent load: tracks the inputs and swallows clock edges.
        r_state    <= LOADING;
        r_shift    <= w_load_val;
        r_cnt      <= '0;
        r_joy_data <= w_load_val[W-1];
      end else begin
        if (r_state == LOADING) begin
          r_state <= SHIFTING;
        end
        if (w_clk_rise) begin
          r_shift    <= {r_shift[W-2:0], 1'b1};
          r_joy_data <= r_shift[W-2];
          // IDLE keeps shifting ones but the count holds.
          if (r_state != IDLE) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(W - 2)) begin
              r_frame_done <= 1'b1;
              r_state      <= IDLE;
            end
          end
        end
      end
    end
  end

  assign link.joy_data = r_joy_data;
  assign o_frame_done  = r_frame_done;

endmodule
